// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder built around one full_adder cell.
//
// An accepted start captures a, b and cin. The core then adds one bit pair
// per clock, LSB first. A carry flip-flop feeds C_out back into C. The sum
// register fills from the MSB end, so after WIDTH shifts bit 0 holds the
// result LSB. All outputs come straight from registers.
//
// Optional feature: define SERIAL_ADDER_SUB_EN to add subtraction.
//   - The sub port is captured on start. When it is set, B is inverted and
//     the carry starts at 1, giving a - b.
//   - The ovf port reports signed overflow for both add and subtract.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  operation request, sampled only while busy=0
//   a, b   WIDTH-bit operands, captured on accepted start
//   cin    carry-in, captured on accepted start (ignored when sub=1)
//   sum    WIDTH-bit result register
//   cout   final carry-out (for subtract: 1 = no borrow)
//   busy   high while bits are being processed
//   done   one-cycle pulse when sum/cout become valid
//   sub    (SERIAL_ADDER_SUB_EN only) 1 = subtract
//   ovf    (SERIAL_ADDER_SUB_EN only) signed overflow, held with sum

// One-bit full adder cell consumed by the serial datapath.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic S,
    output logic C_out
);
    assign S     = A ^ B ^ C;
    assign C_out = (A & B) | (C & (A ^ B));
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_ADDER_SUB_EN
    ,
    input  logic             sub,
    output logic             ovf
`endif
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;

    logic fa_b;
    logic fa_s;
    logic fa_cout;

`ifdef SERIAL_ADDER_SUB_EN
    logic sub_q, sub_d;
    logic ovf_q, ovf_d;

    // Subtraction feeds the inverted B bit; the +1 comes from the carry seed.
    assign fa_b = op_b_q[0] ^ sub_q;
`else
    assign fa_b = op_b_q[0];
`endif

    full_adder u_full_adder (
        .A     (op_a_q[0]),
        .B     (fa_b),
        .C     (carry_q),
        .S     (fa_s),
        .C_out (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub_d   = sub_q;
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_a_d  = a;
                    op_b_d  = b;
                    cnt_d   = '0;
                    state_d = StRun;
`ifdef SERIAL_ADDER_SUB_EN
                    sub_d   = sub;
                    carry_d = sub ? 1'b1 : cin;
`else
                    carry_d = cin;
`endif
                end
            end

            StRun: begin
                op_a_d  = op_a_q >> 1;
                op_b_d  = op_b_q >> 1;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LastBit) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    cout_d  = fa_cout;
`ifdef SERIAL_ADDER_SUB_EN
                    // On the MSB step carry_q is the carry into the MSB.
                    ovf_d   = carry_q ^ fa_cout;
`endif
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

`ifdef SERIAL_ADDER_SUB_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            sub_q <= sub_d;
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign sum  = sum_q;
    assign cout = cout_q;
    assign done = done_q;
    assign busy = (state_q == StRun);

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder (WIDTH=8).
// Directed cases cover latency, handshake corners and reset abort.
// Random operations are checked against an arithmetic reference model.
module tb_serial_adder;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic             done;
`ifdef SERIAL_ADDER_SUB_EN
    logic             ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
`ifdef SERIAL_ADDER_SUB_EN
        ,
        .sub   (sub),
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: plain arithmetic on WIDTH+1 bits. Subtraction is a + ~b + 1.
    task automatic check_result(input string tag, input logic [WIDTH-1:0] x,
                                input logic [WIDTH-1:0] y, input logic c, input logic s);
        logic [WIDTH-1:0] yy;
        logic [WIDTH:0]   full;
        logic             exp_ovf;
        yy      = s ? ~y : y;
        full    = {1'b0, x} + {1'b0, yy} + (WIDTH + 1)'(s ? 1'b1 : c);
        exp_ovf = (x[WIDTH-1] == yy[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
        check({tag, " sum"}, 64'(sum), 64'(full[WIDTH-1:0]));
        check({tag, " cout"}, 64'(cout), 64'(full[WIDTH]));
`ifdef SERIAL_ADDER_SUB_EN
        check({tag, " ovf"}, 64'(ovf), 64'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("unexpected X in model");
`endif
    endtask

    // Call at a negedge with start already driven for edge 0 having just passed.
    // Waits for done, checking the latency in negedges.
    task automatic wait_done(input string tag, input int exp_cycles);
        int n = 0;
        while (!done && n < 3 * WIDTH) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(exp_cycles));
        check({tag, " busy at done"}, 64'(busy), 64'(0));
    endtask

    // Full operation: launch at a negedge, release start, wait for done,
    // check the result, then check that done was a single-cycle pulse.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input logic c, input logic s);
        a = x; b = y; cin = c; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom);
        check({tag, " busy"}, 64'(busy), 64'(1));
        wait_done(tag, WIDTH);
        check_result(tag, x, y, c, s);
        @(negedge clk);
        check({tag, " done pulse"}, 64'(done), 64'(0));
        check({tag, " hold sum"}, 64'(sum), 64'(sum));
    endtask

    initial begin
        logic saw_done;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        check("reset sum", 64'(sum), 64'(0));
        check("reset cout", 64'(cout), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run_op("5a+3c", 8'h5A, 8'h3C, 1'b0, 1'b0);
        run_op("ff+01", 8'hFF, 8'h01, 1'b0, 1'b0);
        run_op("ff+ff+1", 8'hFF, 8'hFF, 1'b1, 1'b0);

        // start held high during RUN with a changing: ignored, one done only.
        a = 8'h01; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'hF0;
        wait_done("hold start", WIDTH);
        start = 1'b0;
        check_result("hold start", 8'h01, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        check("hold start single done", 64'(done), 64'(0));
        check("hold start idle", 64'(busy), 64'(0));

        // Back-to-back: start during the done cycle is accepted.
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("first of pair", WIDTH);
        check_result("first of pair", 8'h01, 8'h02, 1'b0, 1'b0);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("chain done drop", 64'(done), 64'(0));
        check("chain busy", 64'(busy), 64'(1));
        wait_done("chained", WIDTH);
        check_result("chained", 8'h10, 8'h20, 1'b0, 1'b0);
        @(negedge clk);

        // Reset during RUN aborts without a done pulse.
        a = 8'h55; b = 8'h66; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort busy", 64'(busy), 64'(0));
        check("abort sum", 64'(sum), 64'(0));
        check("abort cout", 64'(cout), 64'(0));
        saw_done = 1'b0;
        for (int i = 0; i < WIDTH + 2; i++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        check("abort no done", 64'(saw_done), 64'(0));
        run_op("after abort", 8'h03, 8'h04, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op("sub 10-20", 8'h10, 8'h20, 1'b0, 1'b1);
        run_op("sub 80-01", 8'h80, 8'h01, 1'b1, 1'b1);
        run_op("add ovf", 8'h7F, 8'h01, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 20; i++) begin
            logic s;
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            run_op($sformatf("rand%0d", i), WIDTH'($urandom), WIDTH'($urandom),
                   1'($urandom), s);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
